response_checker: RTL and testbench

- Consumer end of the stimulus/response loop used by the gate-level sims.
- A driver feeds a DUT one vector per cycle. This block receives the DUT's output samples over a valid/ready handshake and compares each one against a golden vector table set by parameter.
- It reports pass/fail, the mismatch count and the first failing index.
- It also flags a stalled stream through a watchdog, so benches end on a hardware verdict instead of a text dump.

---
 rtl/checker_pkg.sv | 17 +
 rtl/golden_rom.sv | 24 ++
 rtl/response_checker.sv | 137 +++++++++++++
 tb/tb_response_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// Shared types and width helper for the response checker and its golden table.
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/golden_rom.sv
// Combinational lookup of one golden sample from the packed parameter table.
module golden_rom
    import checker_pkg::*;
#(
    parameter int                     WIDTH    = 1,
    parameter int                     DEPTH    = 4,
    parameter logic [DEPTH*WIDTH-1:0] EXPECTED = 4'b0111,
    parameter int                     IDX_W    = cnt_w(DEPTH)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] exp_data
);

    // Indices past DEPTH-1 cannot occur but read as zero rather than out of range.
    always_comb begin
        exp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == i[IDX_W-1:0]) begin
                exp_data = EXPECTED[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/response_checker.sv
// Receives DUT output samples over valid/ready, compares them with a golden table
// and reports a pass/fail verdict, mismatch statistics and a stalled-stream watchdog.
module response_checker
    import checker_pkg::*;
#(
    parameter int                     WIDTH    = 1,
    parameter int                     DEPTH    = 4,
    parameter logic [DEPTH*WIDTH-1:0] EXPECTED = 4'b0111,
    parameter int                     TIMEOUT  = 16,
    localparam int                    IDX_W    = cnt_w(DEPTH),
    localparam int                    CNT_W    = $clog2(DEPTH + 1),
    localparam int                    WD_W     = cnt_w(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             obs_valid,
    input  logic [WIDTH-1:0] obs_data,
    output logic             obs_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             first_fail_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
    logic [IDX_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic             first_fail_valid_q, first_fail_valid_d;
    logic             timeout_q, timeout_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] exp_data;
    logic             accept;

    golden_rom #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .EXPECTED (EXPECTED),
        .IDX_W    (IDX_W)
    ) u_rom (
        .idx      (idx_q),
        .exp_data (exp_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            idx_q              <= '0;
            wdog_q             <= '0;
            mismatch_count_q   <= '0;
            first_fail_idx_q   <= '0;
            first_fail_valid_q <= 1'b0;
            timeout_q          <= 1'b0;
            pass_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            wdog_q             <= wdog_d;
            mismatch_count_q   <= mismatch_count_d;
            first_fail_idx_q   <= first_fail_idx_d;
            first_fail_valid_q <= first_fail_valid_d;
            timeout_q          <= timeout_d;
            pass_q             <= pass_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        wdog_d             = wdog_q;
        mismatch_count_d   = mismatch_count_q;
        first_fail_idx_d   = first_fail_idx_q;
        first_fail_valid_d = first_fail_valid_q;
        timeout_d          = timeout_q;
        pass_d             = pass_q;
        busy               = (state_q == CHECK);
        done               = (state_q == DONE);
        obs_ready          = busy;
        accept             = obs_valid && obs_ready;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d            = CHECK;
                    idx_d              = '0;
                    wdog_d             = '0;
                    mismatch_count_d   = '0;
                    first_fail_idx_d   = '0;
                    first_fail_valid_d = 1'b0;
                    timeout_d          = 1'b0;
                    pass_d             = 1'b0;
                end
            end
            CHECK: begin
                // An accept always beats a watchdog expiry in the same cycle.
                if (accept) begin
                    wdog_d = '0;
                    if (obs_data != exp_data) begin
                        mismatch_count_d = mismatch_count_q + 1'b1;
                        if (!first_fail_valid_q) begin
                            first_fail_idx_d   = idx_q;
                            first_fail_valid_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (mismatch_count_d == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (wdog_q == WD_MAX) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pass             = pass_q;
    assign timeout          = timeout_q;
    assign mismatch_count   = mismatch_count_q;
    assign first_fail_idx   = first_fail_idx_q;
    assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_response_checker.sv
// Randomised scoreboard bench for response_checker with the default NAND table.
module tb_response_checker;

   localparam int TIMEOUT = 16;
   localparam int DEPTH   = 4;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       start     = 1'b0;
   logic       obs_valid = 1'b0;
   logic [0:0] obs_data  = 1'b0;
   logic       obs_ready;
   logic       busy;
   logic       done;
   logic       pass;
   logic       timeout;
   logic [2:0] mismatch_count;
   logic [1:0] first_fail_idx;
   logic       first_fail_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit pass;
      bit to;
      int cnt;
      bit ffv;
      int ffi;
   } exp_t;

   exp_t sb[$];
   exp_t lastExp;
   bit   goldenTab[4] = '{1, 1, 1, 0};
   int   runData[4];
   int   runGap[4];
   bit   donePrev = 1'b0;

   response_checker dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .obs_valid        (obs_valid),
      .obs_data         (obs_data),
      .obs_ready        (obs_ready),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .timeout          (timeout),
      .mismatch_count   (mismatch_count),
      .first_fail_idx   (first_fail_idx),
      .first_fail_valid (first_fail_valid)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference verdict: walk the samples in order; a gap of TIMEOUT or more idle
   // cycles before a sample ends the run with a timeout and that sample unseen
   function automatic exp_t model();
      exp_t e;
      e.pass = 1'b0;
      e.to   = 1'b0;
      e.cnt  = 0;
      e.ffv  = 1'b0;
      e.ffi  = 0;
      for (int k = 0; k < DEPTH; k++) begin
         if (runGap[k] >= TIMEOUT) begin
            e.to = 1'b1;
            break;
         end
         if (runData[k] != int'(goldenTab[k])) begin
            if (!e.ffv) begin
               e.ffv = 1'b1;
               e.ffi = k;
            end
            e.cnt++;
         end
      end
      e.pass = !e.to && (e.cnt == 0);
      return e;
   endfunction

   // Monitor: every rising edge of done pops one expected verdict and compares
   always @(negedge clk) begin
      exp_t e;
      if (done && !donePrev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: done rose with no run outstanding");
         end else begin
            e = sb.pop_front();
            checkOutput("verdict_pass", int'(pass), int'(e.pass));
            checkOutput("verdict_timeout", int'(timeout), int'(e.to));
            checkOutput("verdict_count", int'(mismatch_count), e.cnt);
            checkOutput("verdict_ffv", int'(first_fail_valid), int'(e.ffv));
            if (e.ffv) checkOutput("verdict_ffi", int'(first_fail_idx), e.ffi);
         end
      end
      donePrev <= done;
   end

   // Drives one run from runData/runGap, queues its expected verdict, then
   // waits (bounded) for the monitor to consume it
   task automatic applyStimulus();
      exp_t e;
      int   running = 0;
      e = model();
      sb.push_back(e);
      lastExp = e;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("entry_busy", int'(busy), 1);
      checkOutput("entry_done", int'(done), 0);
      checkOutput("entry_count", int'(mismatch_count), 0);
      checkOutput("entry_ffv", int'(first_fail_valid), 0);
      checkOutput("entry_timeout", int'(timeout), 0);
      checkOutput("entry_pass", int'(pass), 0);
      for (int k = 0; k < DEPTH; k++) begin
         if (runGap[k] >= TIMEOUT) begin
            repeat (TIMEOUT) @(negedge clk);
            checkOutput("wdog_done", int'(done), 1);
            break;
         end
         repeat (runGap[k]) @(negedge clk);
         obs_valid = 1'b1;
         obs_data  = runData[k][0];
         if (k == DEPTH - 1) checkOutput("pre_done", int'(done), 0);
         @(negedge clk);
         obs_valid = 1'b0;
         if (runData[k] != int'(goldenTab[k])) running++;
         checkOutput("count_step", int'(mismatch_count), running);
         if (k == DEPTH - 1) checkOutput("done_latency", int'(done), 1);
      end
      for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL verdict_wait: %0d verdicts still pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic setRun(input int d0, d1, d2, d3, g0, g1, g2, g3);
      runData = '{d0, d1, d2, d3};
      runGap  = '{g0, g1, g2, g3};
   endtask

   // Global time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] global timeout");
   end

   // Main sequence: reset, directed runs, back-pressure, random runs, async reset
   initial begin
      int r;
      obs_valid = 1'b1;
      #12;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_ready", int'(obs_ready), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_pass", int'(pass), 0);
      checkOutput("reset_timeout", int'(timeout), 0);
      checkOutput("reset_count", int'(mismatch_count), 0);
      checkOutput("reset_ffi", int'(first_fail_idx), 0);
      checkOutput("reset_ffv", int'(first_fail_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_ready", int'(obs_ready), 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_count", int'(mismatch_count), 0);
      obs_valid = 1'b0;

      setRun(1, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus();
      setRun(1, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus();
      setRun(0, 1, 1, 1, 3, 3, 3, 3);
      applyStimulus();
      setRun(1, 1, 1, 0, 0, 0, 16, 0);
      applyStimulus();
      setRun(1, 1, 1, 0, 0, 0, 15, 0);
      applyStimulus();

      // Samples offered while DONE must be dropped
      setRun(0, 0, 1, 0, 0, 1, 0, 2);
      applyStimulus();
      obs_valid = 1'b1;
      obs_data  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("done_ready", int'(obs_ready), 0);
         checkOutput("done_hold_count", int'(mismatch_count), lastExp.cnt);
         checkOutput("done_hold", int'(done), 1);
      end
      obs_valid = 1'b0;
      setRun(1, 1, 1, 0, 0, 2, 0, 1);
      applyStimulus();

      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < DEPTH; k++) begin
            runData[k] = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            runGap[k] = (r < 17) ? int'($urandom_range(0, 3)) : ((r < 19) ? 15 : 16);
         end
         applyStimulus();
      end

      // Async reset between clock edges in the middle of a run
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      obs_valid = 1'b1;
      obs_data  = 1'b0;
      @(negedge clk);
      obs_data = 1'b1;
      @(negedge clk);
      obs_valid = 1'b0;
      checkOutput("mid_count", int'(mismatch_count), 1);
      checkOutput("mid_ffv", int'(first_fail_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_busy", int'(busy), 0);
      checkOutput("areset_ready", int'(obs_ready), 0);
      checkOutput("areset_done", int'(done), 0);
      checkOutput("areset_count", int'(mismatch_count), 0);
      checkOutput("areset_ffv", int'(first_fail_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      setRun(1, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus();

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
